// File: rtl/data_type_pkg.sv
// Shared datapath types for the lambda metric pipeline.
package data_type_pkg;

  localparam int unsigned LAMBDA_W    = 14;
  localparam int unsigned WIN_LEN_DEF = 256;

  // Q6.8 signed metric sample
  typedef logic signed [LAMBDA_W-1:0] lambda_t;

endpackage

// File: rtl/lambda_argmax.sv
// Windowed argmax over the lambda metric stream: reports index and value of the
// largest sample (earliest wins on ties) once per complete window.
module lambda_argmax
  import data_type_pkg::*;
#(
  parameter int unsigned WIN_LEN = WIN_LEN_DEF,
  parameter int unsigned IDX_W   = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  lambda_t          lambda_in,
  output logic [IDX_W-1:0] theta_out,
  output lambda_t          peak_out,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] cnt, cnt_d;
  lambda_t          max_val, max_val_d;
  logic [IDX_W-1:0] max_idx, max_idx_d;
  logic [IDX_W-1:0] theta_d;
  lambda_t          peak_d;
  logic             out_valid_d;
  logic             gt;
  logic             last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      max_val   <= '0;
      max_idx   <= '0;
      theta_out <= '0;
      peak_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      max_val   <= max_val_d;
      max_idx   <= max_idx_d;
      theta_out <= theta_d;
      peak_out  <= peak_d;
      out_valid <= out_valid_d;
    end
  end

  // The final sample of a window belongs to that window even when start coincides.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    max_val_d   = max_val;
    max_idx_d   = max_idx;
    theta_d     = theta_out;
    peak_d      = peak_out;
    out_valid_d = 1'b0;
    gt          = (lambda_in > max_val);
    last        = (state == SEARCH) && in_valid && (cnt == LAST_IDX);

    if (last) begin
      if (gt) begin
        theta_d = cnt;
        peak_d  = lambda_in;
      end else begin
        theta_d = max_idx;
        peak_d  = max_val;
      end
      out_valid_d = 1'b1;
      cnt_d       = '0;
      state_d     = start ? SEARCH : IDLE;
    end else if (start) begin
      state_d = SEARCH;
      if (in_valid) begin
        max_val_d = lambda_in;
        max_idx_d = '0;
        cnt_d     = IDX_W'(1);
      end else begin
        cnt_d = '0;
      end
    end else if ((state == SEARCH) && in_valid) begin
      if ((cnt == '0) || gt) begin
        max_val_d = lambda_in;
        max_idx_d = cnt;
      end
      cnt_d = cnt + 1'b1;
    end
  end

  assign busy = (state == SEARCH);

endmodule

// File: tb/tb_lambda_argmax.sv
// Directed self-checking bench for lambda_argmax with an 8-sample window.
module tb_lambda_argmax;
  import data_type_pkg::*;

  localparam int unsigned WL = 8;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  lambda_t       lambda_in = '0;
  logic [IW-1:0] theta_out;
  lambda_t       peak_out;
  logic          out_valid;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  int ov_cnt = 0;
  int ov_base;
  int smp[8];

  lambda_argmax #(.WIN_LEN(WL), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .lambda_in (lambda_in),
    .theta_out (theta_out),
    .peak_out  (peak_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid) ov_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge; outputs are settled there too.
  task automatic step(input logic s, input logic v, input int d);
    @(negedge clk);
    start     = s;
    in_valid  = v;
    lambda_in = LAMBDA_W'(d);
  endtask

  task automatic check_result(input string tag, input int th, input int pk);
    check({tag, "_ov"}, int'(out_valid), 1);
    check({tag, "_theta"}, int'(theta_out), th);
    check({tag, "_peak"}, int'($signed(peak_out)), pk);
  endtask

  initial begin
    #2;
    check("rst_theta", int'(theta_out), 0);
    check("rst_peak", int'($signed(peak_out)), 0);
    check("rst_ov", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // basic window
    smp = '{1, 5, 3, 9, 2, 0, -4, 7};
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, smp[i]);
    step(0, 0, 0);
    check_result("w1", 3, 9);
    check("w1_busy", int'(busy), 0);
    step(0, 0, 0);
    check("w1_ov_pulse", int'(out_valid), 0);
    check("w1_hold_theta", int'(theta_out), 3);

    // extremes, first sample coincident with start
    smp = '{-8192, -8192, -8192, -8192, -8192, 8191, -8192, -8192};
    step(1, 1, smp[0]);
    for (int i = 1; i < 8; i++) step(0, 1, smp[i]);
    step(0, 0, 0);
    check_result("ext", 5, 8191);

    // all equal: earliest index wins
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 6);
    step(0, 0, 0);
    check_result("eq", 0, 6);

    // gapped valid stream
    smp = '{1, 5, 3, 9, 2, 0, -4, 7};
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 4); g++) step(0, 0, 99);
      step(0, 1, smp[i]);
    end
    step(0, 0, 0);
    check_result("gap", 3, 9);

    // abort then restart, start carries index 0
    step(0, 0, 0);
    ov_base = ov_cnt;
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 100);
    smp = '{0, 0, 2, 0, 0, 0, 0, 0};
    step(1, 1, smp[0]);
    for (int i = 1; i < 8; i++) step(0, 1, smp[i]);
    step(0, 0, 0);
    check_result("abort", 2, 2);
    step(0, 0, 0);
    step(0, 0, 0);
    check("abort_ov_count", ov_cnt - ov_base, 1);

    // asynchronous reset mid-window
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 50);
    #2 rst = 1'b1;
    #1;
    check("arst_theta", int'(theta_out), 0);
    check("arst_peak", int'($signed(peak_out)), 0);
    check("arst_busy", int'(busy), 0);
    #1 rst = 1'b0;
    ov_base = ov_cnt;
    for (int i = 0; i < 6; i++) step(0, 1, 70);
    step(0, 0, 0);
    step(0, 0, 0);
    check("arst_no_ov", ov_cnt - ov_base, 0);
    check("arst_idle_busy", int'(busy), 0);
    smp = '{-3, -1, -2, -1, -5, -7, -1, -9};
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, smp[i]);
    step(0, 0, 0);
    check_result("post_rst", 1, -1);

    // start coincident with the final sample
    smp = '{4, 4, 4, 4, 4, 4, 4, 10};
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, smp[i]);
    step(1, 1, smp[7]);
    step(0, 0, 0);
    check_result("coin1", 7, 10);
    check("coin1_busy", int'(busy), 1);
    smp = '{3, 8, 8, 1, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) step(0, 1, smp[i]);
    step(0, 0, 0);
    check_result("coin2", 1, 8);
    check("coin2_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
